// File: rtl/multiciclo_pkg.sv
// Shared encodings, state/ALU enums and helpers for the multiciclo core.
package multiciclo_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_R  = 7'h33;
  localparam logic [6:0] OP_I  = 7'h13;
  localparam logic [6:0] OP_LW = 7'h03;
  localparam logic [6:0] OP_SW = 7'h23;
  localparam logic [6:0] OP_BR = 7'h63;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, TRAP} state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

  // Per-cycle control strobes from the controller to the datapath
  typedef struct packed {
    logic irwrite;
    logic pcwrite;
    logic pcbranch;
    logic regwrite;
    logic mdrwrite;
    logic memreq;
    logic memwe;
    logic retire;
  } ctrl_t;

  function automatic logic [XLEN-1:0] imm_i(input logic [XLEN-1:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  function automatic logic [XLEN-1:0] imm_s(input logic [XLEN-1:0] ir);
    return {{20{ir[31]}}, ir[31:25], ir[11:7]};
  endfunction

  function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] ir);
    return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] alu(input alu_op_t op, input logic [XLEN-1:0] x,
                                          input logic [XLEN-1:0] y);
    case (op)
      ALU_ADD: return x + y;
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_XOR: return x ^ y;
      ALU_SLT: return {31'b0, $signed(x) < $signed(y)};
      ALU_SLL: return x << y[4:0];
      ALU_SRL: return x >> y[4:0];
      ALU_SRA: return XLEN'($signed(x) >>> y[4:0]);
      default: return x + y;
    endcase
  endfunction

endpackage

// File: rtl/multiciclo_ctrl.sv
// Controller: instruction decode and the FETCH/DECODE/EXECUTE/MEM/WB/TRAP sequencer.
module multiciclo_ctrl
  import multiciclo_pkg::*;
#(
  parameter int unsigned NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] ir,
  input  logic            mem_ack,
  input  logic [1:0]      addr_lo,
  input  logic            operands_eq,
  output state_t          state,
  output ctrl_t           strobe,
  output alu_op_t         alu_op,
  output logic [XLEN-1:0] alu_imm,
  output logic            alu_use_imm,
  output logic            is_lw,
  output logic            trap
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;
  logic       legal, uses_rs1, uses_rs2, uses_rd, is_sw, is_br, reg_bad, taken;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  function automatic logic idx_bad(input logic [4:0] idx);
    return {1'b0, idx} >= 6'(NREG);
  endfunction

  assign reg_bad = (uses_rs1 && idx_bad(rs1)) || (uses_rs2 && idx_bad(rs2)) ||
                   (uses_rd && idx_bad(rd));
  assign taken   = (funct3 == F3_BEQ) ? operands_eq : !operands_eq;

  // Decode the held instruction into ALU controls and legality
  always_comb begin
    legal       = 1'b0;
    alu_op      = ALU_ADD;
    alu_use_imm = 1'b0;
    alu_imm     = imm_i(ir);
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    uses_rd     = 1'b0;
    is_lw       = 1'b0;
    is_sw       = 1'b0;
    is_br       = 1'b0;
    case (opcode)
      OP_R: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        uses_rd  = 1'b1;
        legal    = (funct7 == F7_BASE);
        case (funct3)
          F3_ADD: begin
            alu_op = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          F3_SLL: alu_op = ALU_SLL;
          F3_SLT: alu_op = ALU_SLT;
          F3_XOR: alu_op = ALU_XOR;
          F3_OR:  alu_op = ALU_OR;
          F3_AND: alu_op = ALU_AND;
          F3_SR: begin
            alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          default: legal = 1'b0;
        endcase
      end
      OP_I: begin
        uses_rs1    = 1'b1;
        uses_rd     = 1'b1;
        alu_use_imm = 1'b1;
        legal       = 1'b1;
        case (funct3)
          F3_ADD: alu_op = ALU_ADD;
          F3_SLT: alu_op = ALU_SLT;
          F3_XOR: alu_op = ALU_XOR;
          F3_OR:  alu_op = ALU_OR;
          F3_AND: alu_op = ALU_AND;
          F3_SLL: begin
            alu_op = ALU_SLL;
            legal  = (funct7 == F7_BASE);
          end
          F3_SR: begin
            alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          default: legal = 1'b0;
        endcase
      end
      OP_LW: begin
        uses_rs1    = 1'b1;
        uses_rd     = 1'b1;
        alu_use_imm = 1'b1;
        is_lw       = 1'b1;
        legal       = (funct3 == F3_W);
      end
      OP_SW: begin
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        alu_use_imm = 1'b1;
        alu_imm     = imm_s(ir);
        is_sw       = 1'b1;
        legal       = (funct3 == F3_W);
      end
      OP_BR: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        is_br    = 1'b1;
        legal    = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
      end
      default: legal = 1'b0;
    endcase
  end

  // Sequencer; halt is latched on the transition into TRAP
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= FETCH;
      trap  <= 1'b0;
    end else begin
      case (state)
        FETCH: if (mem_ack) state <= DECODE;
        DECODE: begin
          if (!legal || reg_bad) begin
            state <= TRAP;
            trap  <= 1'b1;
          end else begin
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (is_lw || is_sw) begin
            if (addr_lo != 2'b00) begin
              state <= TRAP;
              trap  <= 1'b1;
            end else begin
              state <= MEM;
            end
          end else if (is_br) begin
            state <= FETCH;
          end else begin
            state <= WB;
          end
        end
        MEM:  if (mem_ack) state <= is_lw ? WB : FETCH;
        WB:   state <= FETCH;
        TRAP: state <= TRAP;
        default: begin
          state <= TRAP;
          trap  <= 1'b1;
        end
      endcase
    end
  end

  // Per-state datapath strobes
  always_comb begin
    strobe = '0;
    case (state)
      FETCH: begin
        strobe.memreq  = 1'b1;
        strobe.irwrite = mem_ack;
        strobe.pcwrite = mem_ack;
      end
      EXECUTE: begin
        strobe.pcbranch = is_br && taken;
        strobe.retire   = is_br;
      end
      MEM: begin
        strobe.memreq   = 1'b1;
        strobe.memwe    = is_sw;
        strobe.mdrwrite = mem_ack && is_lw;
        strobe.retire   = mem_ack && is_sw;
      end
      WB: begin
        strobe.regwrite = 1'b1;
        strobe.retire   = 1'b1;
      end
      default: strobe = '0;
    endcase
  end

endmodule

// File: rtl/multiciclo.sv
// Multi-cycle RV32I-subset core: datapath, register file and ALU around the controller.
module multiciclo
  import multiciclo_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NREG     = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_ack_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] salida_o,
  output logic            retire_o,
  output logic            halt_o
);

  localparam int unsigned RIDX_W = $clog2(NREG);

  logic [XLEN-1:0] pc, ir, oldpc, a, b, aluout, mdr, salida;
  logic [XLEN-1:0] rf [NREG];
  logic [XLEN-1:0] rf_rs1, rf_rs2, alu_b, alu_y, wb_val;
  logic [XLEN-1:0] alu_imm;
  logic [4:0]      rs1, rs2, rd;
  logic            alu_use_imm, is_lw, trap;
  state_t          state;
  ctrl_t           strobe;
  alu_op_t         alu_op;

  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];

  multiciclo_ctrl #(.NREG(NREG)) u_ctrl (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ir          (ir),
    .mem_ack     (mem_ack_i),
    .addr_lo     (alu_y[1:0]),
    .operands_eq (a == b),
    .state       (state),
    .strobe      (strobe),
    .alu_op      (alu_op),
    .alu_imm     (alu_imm),
    .alu_use_imm (alu_use_imm),
    .is_lw       (is_lw),
    .trap        (trap)
  );

  // Combinational register reads; x0 and out-of-range indices read zero
  always_comb begin
    rf_rs1 = '0;
    rf_rs2 = '0;
    if (rs1 != 5'd0 && {1'b0, rs1} < 6'(NREG)) rf_rs1 = rf[rs1[RIDX_W-1:0]];
    if (rs2 != 5'd0 && {1'b0, rs2} < 6'(NREG)) rf_rs2 = rf[rs2[RIDX_W-1:0]];
  end

  assign alu_b  = alu_use_imm ? alu_imm : b;
  assign alu_y  = alu(alu_op, a, alu_b);
  assign wb_val = is_lw ? mdr : aluout;

  // Architectural and pipeline-holding registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc     <= RESET_PC;
      ir     <= '0;
      oldpc  <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      mdr    <= '0;
      salida <= '0;
    end else begin
      if (strobe.irwrite) begin
        ir    <= mem_rdata_i;
        oldpc <= pc;
      end
      if (strobe.pcwrite) pc <= pc + 32'd4;
      if (strobe.pcbranch) pc <= aluout;
      if (state == DECODE) begin
        a      <= rf_rs1;
        b      <= rf_rs2;
        aluout <= oldpc + imm_b(ir);
      end
      if (state == EXECUTE && !strobe.retire) aluout <= alu_y;
      if (strobe.mdrwrite) mdr <= mem_rdata_i;
      if (strobe.regwrite) salida <= wb_val;
    end
  end

  // Register file write port; x0 is never written
  always_ff @(posedge clk_i) begin
    if (strobe.regwrite && rd != 5'd0) rf[rd[RIDX_W-1:0]] <= wb_val;
  end

  assign mem_req_o   = strobe.memreq && !rst_i;
  assign mem_we_o    = strobe.memwe;
  assign mem_addr_o  = (state == MEM) ? aluout : pc;
  assign mem_wdata_o = b;
  assign pc_o        = pc;
  assign salida_o    = salida;
  assign retire_o    = strobe.retire;
  assign halt_o      = trap;

endmodule
